// File: rtl/car_scheduler.sv
// car_scheduler: once per frame advances the x position of the 10 car sprites
// through one shared adder, one car per cycle. It also reloads the spawn
// positions when the level changes.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for an unpaused frame_tick
// RELOAD  | level changed: all cars return to spawn x; no motion this frame
// UPDATE  | car idx is moved by its lane speed and direction; idx advances
// DONE    | one-cycle update_done pulse, then back to IDLE
module car_scheduler (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         frame_tick,
    input  logic         pause,
    input  logic [3:0]   current_level,
    output logic [99:0]  car_x_bus,
    output logic [99:0]  car_y_bus,
    output logic         busy,
    output logic         update_done,
    output logic         overrun
);

    localparam int        NUM_CARS   = 10;
    localparam int        SPAWN_GAP  = 336;
    localparam int        LANE_Y0    = 96;
    localparam int        LANE_PITCH = 64;
    localparam logic [10:0] H_WRAP   = 11'd672;

    typedef enum logic [1:0] {S_IDLE, S_RELOAD, S_UPDATE, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [3:0]  level_q;
    logic [3:0]  idx;
    logic [9:0]  car_x [NUM_CARS];
    logic [9:0]  cur_x;
    logic [9:0]  next_x;
    logic [4:0]  spd;
    logic [10:0] sum_r;
    logic [10:0] next_x_w;
    logic        tick_go;

    function automatic logic [9:0] spawn_x(input int i);
        int v;
        v = (((i % 2) != 0) ? SPAWN_GAP : 0) + (i / 2) * 48;
        return v[9:0];
    endfunction

    function automatic logic [9:0] lane_y(input int i);
        int v;
        v = LANE_Y0 + (i / 2) * LANE_PITCH;
        return v[9:0];
    endfunction

    assign tick_go = frame_tick && !pause;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode and status outputs
    always_comb begin
        state_nxt   = state;
        busy        = 1'b0;
        update_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (tick_go) begin
                    if (current_level != level_q) state_nxt = S_RELOAD;
                    else                          state_nxt = S_UPDATE;
                end
            end
            S_RELOAD: begin
                busy      = 1'b1;
                state_nxt = S_IDLE;
            end
            S_UPDATE: begin
                busy = 1'b1;
                if (idx == 4'(NUM_CARS - 1)) state_nxt = S_DONE;
            end
            S_DONE: begin
                update_done = 1'b1;
                state_nxt   = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Shared adder: new x for car idx. idx[1] is the lane parity, so odd lanes move left
    always_comb begin
        cur_x = '0;
        for (int i = 0; i < NUM_CARS; i++) begin
            if (idx == i[3:0]) cur_x = car_x[i];
        end
        spd   = (level_q == 4'd0) ? 5'd0 : ({1'b0, level_q} + {4'd0, idx[0]});
        sum_r = {1'b0, cur_x} + {6'd0, spd};
        if (idx[1]) begin
            if ({1'b0, cur_x} < {6'd0, spd}) next_x_w = {1'b0, cur_x} + H_WRAP - {6'd0, spd};
            else                             next_x_w = {1'b0, cur_x} - {6'd0, spd};
        end else begin
            next_x_w = (sum_r >= H_WRAP) ? (sum_r - H_WRAP) : sum_r;
        end
        next_x = next_x_w[9:0];
    end

    // Level latch, car index, car positions and sticky overrun
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q <= '0;
            idx     <= '0;
            overrun <= 1'b0;
            for (int i = 0; i < NUM_CARS; i++) car_x[i] <= spawn_x(i);
        end else begin
            if (frame_tick && (state != S_IDLE)) overrun <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (tick_go) begin
                        level_q <= current_level;
                        idx     <= '0;
                    end
                end
                S_RELOAD: begin
                    for (int i = 0; i < NUM_CARS; i++) car_x[i] <= spawn_x(i);
                end
                S_UPDATE: begin
                    for (int i = 0; i < NUM_CARS; i++) begin
                        if (idx == i[3:0]) car_x[i] <= next_x;
                    end
                    idx <= idx + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Pack registered x positions and constant lane y values onto the buses
    always_comb begin
        car_x_bus = '0;
        car_y_bus = '0;
        for (int i = 0; i < NUM_CARS; i++) begin
            car_x_bus[10*i +: 10] = car_x[i];
            car_y_bus[10*i +: 10] = lane_y(i);
        end
    end

endmodule

// File: tb/tb_car_scheduler.sv
// Bench for car_scheduler: a reference model predicts each frame's positions and
// timing; a monitor checks update_done pulses and the busy window against it.
module tb_car_scheduler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         frame_tick;
    logic         pause;
    logic [3:0]   current_level;
    logic [99:0]  car_x_bus;
    logic [99:0]  car_y_bus;
    logic         busy;
    logic         update_done;
    logic         overrun;

    car_scheduler dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .pause(pause),
        .current_level(current_level), .car_x_bus(car_x_bus), .car_y_bus(car_y_bus),
        .busy(busy), .update_done(update_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          done_cyc;
        logic [99:0] xb;
    } exp_t;
    exp_t exp_q[$];

    // reference model state
    int xm [10];
    int lvl_m   = 0;
    int ovr_m   = 0;
    int free_at = 0;
    int busy_lo = 0;
    int busy_hi = -1;

    task automatic chk(input string name, input logic [99:0] act, input logic [99:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int spawn(input int i);
        return ((i % 2) != 0 ? 336 : 0) + (i / 2) * 48;
    endfunction

    function automatic logic [99:0] model_bus();
        logic [99:0] b;
        int v;
        b = '0;
        for (int i = 0; i < 10; i++) begin
            v = xm[i];
            b[10*i +: 10] = v[9:0];
        end
        return b;
    endfunction

    function automatic logic [99:0] spawn_bus();
        logic [99:0] b;
        int v;
        b = '0;
        for (int i = 0; i < 10; i++) begin
            v = spawn(i);
            b[10*i +: 10] = v[9:0];
        end
        return b;
    endfunction

    function automatic logic [99:0] y_bus();
        logic [99:0] b;
        int v;
        b = '0;
        for (int i = 0; i < 10; i++) begin
            v = 96 + (i / 2) * 64;
            b[10*i +: 10] = v[9:0];
        end
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 10; i++) xm[i] = spawn(i);
        lvl_m   = 0;
        ovr_m   = 0;
        free_at = 0;
        if (busy_hi > cyc) busy_hi = cyc;
        exp_q.delete();
    endtask

    // Drive a one-cycle tick and update the model as the spec dictates
    task automatic issue_tick();
        int c;
        int spd;
        exp_t e;
        @(negedge clk);
        c = cyc;
        if (c < free_at) begin
            ovr_m = 1;
        end else if (!pause) begin
            if (int'(current_level) != lvl_m) begin
                lvl_m = int'(current_level);
                for (int i = 0; i < 10; i++) xm[i] = spawn(i);
                free_at = c + 2;
                busy_lo = c + 1;
                busy_hi = c + 1;
            end else begin
                for (int i = 0; i < 10; i++) begin
                    spd = (lvl_m == 0) ? 0 : lvl_m + (i % 2);
                    if (((i / 2) % 2) == 0) xm[i] = (xm[i] + spd) % 672;
                    else                    xm[i] = (xm[i] - spd + 672) % 672;
                end
                e.done_cyc = c + 11;
                e.xb       = model_bus();
                exp_q.push_back(e);
                free_at = c + 12;
                busy_lo = c + 1;
                busy_hi = c + 10;
            end
        end
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        model_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: busy window every cycle, and each update_done against the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if (busy !== ((cyc >= busy_lo) && (cyc <= busy_hi))) begin
                bad++;
                $display("FAIL busy actual=%b required=%b (cyc %0d)", busy, !busy, cyc);
            end
            if (exp_q.size() > 0 && exp_q[0].done_cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL done_missing actual=none required=cyc%0d", exp_q[0].done_cyc);
                void'(exp_q.pop_front());
            end
            if (update_done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL done_unexpected actual=1 required=0 (cyc %0d)", cyc);
                end else begin
                    chk("done_latency", 100'(cyc), 100'(exp_q[0].done_cyc));
                    chk("frame_x", car_x_bus, exp_q[0].xb);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        frame_tick    = 1'b0;
        pause         = 1'b0;
        current_level = 4'd0;
        model_reset();
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(1);

        // reset state
        chk("rst_busy", 100'(busy), 100'(0));
        chk("rst_done", 100'(update_done), 100'(0));
        chk("rst_overrun", 100'(overrun), 100'(0));
        chk("rst_x", car_x_bus, spawn_bus());
        chk("y_bus", car_y_bus, y_bus());

        // level 0: full update sequence, no motion
        issue_tick();
        wait_cycles(12);
        chk("lvl0_car1", 100'(car_x_bus[19:10]), 100'(336));

        // level 0 -> 3: reload, then one frame of motion
        current_level = 4'd3;
        issue_tick();
        wait_cycles(3);
        chk("reload_x", car_x_bus, spawn_bus());
        issue_tick();
        wait_cycles(12);
        chk("l3_car0", 100'(car_x_bus[9:0]),   100'(3));
        chk("l3_car1", 100'(car_x_bus[19:10]), 100'(340));
        chk("l3_car2", 100'(car_x_bus[29:20]), 100'(45));
        chk("l3_car3", 100'(car_x_bus[39:30]), 100'(380));

        // level 15: back-to-back ticks 12 cycles apart, car0 wraps 660 -> 3
        current_level = 4'd15;
        issue_tick();
        wait_cycles(1);
        for (int f = 0; f < 45; f++) begin
            issue_tick();
            wait_cycles(10);
        end
        wait_cycles(2);
        chk("wrap_car0", 100'(car_x_bus[9:0]), 100'(3));
        chk("wrap_x", car_x_bus, model_bus());
        chk("no_overrun", 100'(overrun), 100'(0));

        // overrun: second tick 4 cycles after the first
        issue_tick();
        wait_cycles(2);
        issue_tick();
        wait_cycles(12);
        chk("overrun_set", 100'(overrun), 100'(1));
        chk("overrun_x", car_x_bus, model_bus());

        // pause: ticks ignored, then one advance
        pause = 1'b1;
        for (int f = 0; f < 5; f++) begin
            issue_tick();
            wait_cycles(11);
        end
        chk("pause_x", car_x_bus, model_bus());
        pause = 1'b0;
        issue_tick();
        wait_cycles(12);
        chk("unpause_x", car_x_bus, model_bus());

        // reset in the middle of an update sequence
        issue_tick();
        wait_cycles(3);
        do_reset();
        chk("midrst_busy", 100'(busy), 100'(0));
        chk("midrst_overrun", 100'(overrun), 100'(0));
        chk("midrst_x", car_x_bus, spawn_bus());
        issue_tick();   // level_q back to 0, so level 15 forces a reload
        wait_cycles(4);
        chk("midrst_reload_x", car_x_bus, spawn_bus());

        // randomized frames: level, pause and gaps vary; mid-sequence changes too
        for (int f = 0; f < 70; f++) begin
            int gap;
            if ($urandom_range(0, 3) == 0) current_level = 4'($urandom_range(0, 15));
            pause = ($urandom_range(0, 4) == 0);
            issue_tick();
            gap = int'($urandom_range(0, 14));
            wait_cycles(gap / 2);
            if ($urandom_range(0, 2) == 0) current_level = 4'($urandom_range(0, 15));
            pause = ($urandom_range(0, 1) == 0);
            wait_cycles(gap - gap / 2);
        end
        pause = 1'b0;
        wait_cycles(20);
        chk("final_x", car_x_bus, model_bus());
        chk("final_overrun", 100'(overrun), 100'(ovr_m));
        chk("final_y", car_y_bus, y_bus());
        chk("queue_empty", 100'(exp_q.size()), 100'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
